// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I-subset core: sequences fetch, decode,
// execute, memory and writeback over one shared memory port and counts retires.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             alu_b_sel,
  output logic [1:0]       alu_op,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_NONE   = 4'd0,
    C_R      = 4'd1,
    C_IALU   = 4'd2,
    C_LOAD   = 4'd3,
    C_STORE  = 4'd4,
    C_BRANCH = 4'd5,
    C_JAL    = 4'd6,
    C_JALR   = 4'd7,
    C_LUI    = 4'd8
  } class_t;

  state_t cur_state, nxt_state;
  class_t cls, dec_cls;

  logic       req_c, we_c, asel_c, irwe_c, pcwe_c, rfwe_c, bsel_c, ill_c, ret_c;
  logic [1:0] pcsrc_c, wbsel_c, aluop_c;

  always_comb begin
    dec_cls = C_NONE;
    case (inst[6:0])
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_IALU;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: dec_cls = C_BRANCH;
      7'b1101111: dec_cls = C_JAL;
      7'b1100111: dec_cls = C_JALR;
      7'b0110111: dec_cls = C_LUI;
      default:    dec_cls = C_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_FETCH;
      cls       <= C_NONE;
      instret   <= '0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == S_DECODE) cls <= dec_cls;
      if (ret_c) instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    nxt_state = cur_state;
    req_c     = 1'b0;
    we_c      = 1'b0;
    asel_c    = 1'b0;
    irwe_c    = 1'b0;
    pcwe_c    = 1'b0;
    pcsrc_c   = 2'b00;
    rfwe_c    = 1'b0;
    wbsel_c   = 2'b00;
    bsel_c    = 1'b0;
    aluop_c   = 2'b00;
    ill_c     = 1'b0;
    ret_c     = 1'b0;
    case (cur_state)
      S_FETCH: begin
        req_c  = 1'b1;
        irwe_c = mem_ready;
        if (mem_ready) nxt_state = S_DECODE;
      end
      S_DECODE: begin
        if (dec_cls == C_NONE)     nxt_state = S_TRAP;
        else if (dec_cls == C_LUI) nxt_state = S_WB;
        else                       nxt_state = S_EXEC;
      end
      S_EXEC: begin
        nxt_state = S_WB;
        case (cls)
          C_R: aluop_c = 2'b01;
          C_IALU: begin
            aluop_c = 2'b01;
            bsel_c  = 1'b1;
          end
          C_LOAD, C_STORE: begin
            bsel_c    = 1'b1;
            nxt_state = S_MEM;
          end
          C_JALR: bsel_c = 1'b1;
          C_BRANCH: begin
            aluop_c   = 2'b10;
            pcwe_c    = 1'b1;
            pcsrc_c   = branch_taken ? 2'b01 : 2'b00;
            ret_c     = 1'b1;
            nxt_state = S_FETCH;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        req_c  = 1'b1;
        asel_c = 1'b1;
        we_c   = (cls == C_STORE);
        if (mem_ready) begin
          if (cls == C_STORE) begin
            pcwe_c    = 1'b1;
            ret_c     = 1'b1;
            nxt_state = S_FETCH;
          end else begin
            nxt_state = S_WB;
          end
        end
      end
      S_WB: begin
        rfwe_c    = 1'b1;
        pcwe_c    = 1'b1;
        ret_c     = 1'b1;
        nxt_state = S_FETCH;
        case (cls)
          C_LOAD: wbsel_c = 2'b01;
          C_LUI:  wbsel_c = 2'b11;
          C_JAL: begin
            wbsel_c = 2'b10;
            pcsrc_c = 2'b01;
          end
          C_JALR: begin
            wbsel_c = 2'b10;
            pcsrc_c = 2'b10;
          end
          default: ;
        endcase
      end
      S_TRAP: ill_c = 1'b1;
      default: nxt_state = S_FETCH;
    endcase
  end

  // Reset must silence the port immediately, even though FETCH itself requests.
  assign mem_req      = rst_n & req_c;
  assign mem_we       = rst_n & we_c;
  assign mem_addr_sel = rst_n & asel_c;
  assign ir_we        = rst_n & irwe_c;
  assign pc_we        = rst_n & pcwe_c;
  assign pc_src       = {2{rst_n}} & pcsrc_c;
  assign rf_we        = rst_n & rfwe_c;
  assign wb_sel       = {2{rst_n}} & wbsel_c;
  assign alu_b_sel    = rst_n & bsel_c;
  assign alu_op       = {2{rst_n}} & aluop_c;
  assign illegal      = rst_n & ill_c;
  assign retire       = rst_n & ret_c;
  assign state        = {3{rst_n}} & cur_state;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the RV32I-subset core. It sequences instruction fetch, decode, execute, memory access and writeback over a shared single-port memory. It drives all datapath select and enable lines, including the ImmGen-consumer muxes and the PC/IR/register-file write enables. It also counts retired instructions and traps on unsupported opcodes.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- inst  in  32  current IR contents; stable from DECODE until instruction retires
- mem_ready  in  1  memory completes the current request this cycle
- branch_taken  in  1  ALU compare result for current branch (funct3-resolved in ALU)
- mem_req  out  1  memory request valid
- mem_we  out  1  request is a write
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_we  out  1  load IR from memory read data
- pc_we  out  1  update PC this cycle
- pc_src  out  2  00 PC+4, 01 PC+imm, 10 ALU result with bit0 cleared
- rf_we  out  1  register-file write enable
- wb_sel  out  2  00 ALU, 01 memory data, 10 PC+4, 11 imm
- alu_b_sel  out  1  0 = rs2, 1 = imm
- alu_op  out  2  00 add, 01 funct-decoded, 10 branch compare
- state  out  3  current state encoding (debug)
- illegal  out  1  sticky trap flag
- retire  out  1  one-cycle pulse per retired instruction
- instret  out  CNT_W  retired-instruction count

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- FETCH: mem_req=1, mem_addr_sel=0. ir_we=mem_ready. On mem_ready go to DECODE, else hold.
- DECODE: latch class from inst[6:0]:
  - R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111.
  - LUI goes to WB. Any other listed class goes to EXEC. An unlisted opcode goes to TRAP.
- EXEC:
  - R: alu_op=01, alu_b_sel=0, then WB.
  - I-ALU: alu_op=01, alu_b_sel=1, then WB.
  - LOAD/STORE/JALR: alu_op=00, alu_b_sel=1; LOAD/STORE go to MEM, JALR to WB.
  - BRANCH: alu_op=10, alu_b_sel=0, pc_we=1, pc_src=branch_taken?01:00, retire=1, then FETCH.
  - JAL: no ALU requirement, then WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=(STORE). Hold until mem_ready.
  - LOAD then goes to WB.
  - STORE: on mem_ready, pc_we=1, pc_src=00, retire=1, then FETCH.
- WB: rf_we=1, pc_we=1, retire=1, then FETCH. wb_sel and pc_src per class:
  - R and I-ALU: wb_sel=00, pc_src=00.
  - LOAD: wb_sel=01, pc_src=00.
  - LUI: wb_sel=11, pc_src=00.
  - JAL: wb_sel=10, pc_src=01.
  - JALR: wb_sel=10, pc_src=10.
- TRAP: illegal=1, every enable 0, mem_req=0. The block stays in TRAP until reset.
- Default for every output not stated above is 0.
- instret increments by 1 on each retire. It wraps from 2^CNT_W-1 to 0.

## Timing
- Reset (rst_n low, asynchronous): state=FETCH, instret=0, illegal=0, class register cleared. All outputs are forced 0 while rst_n is low, including mem_req.
- First cycle after reset release is FETCH with mem_req=1.
- Reset mid-instruction aborts the instruction immediately. No retire pulse, no partial write.
- Select outputs are Moore from state and class. ir_we, pc_we on STORE and BRANCH, and retire are Mealy on mem_ready or branch_taken.
- While waiting for mem_ready, mem_req, mem_we and mem_addr_sel stay stable. mem_ready outside FETCH/MEM is ignored.
- Cycle counts with mem_ready=1 on first request cycle:
  - BRANCH and LUI: 3 cycles.
  - R, I-ALU, STORE, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - Each extra wait cycle adds 1.
- retire and the final pc_we occur in the same cycle. The next FETCH follows on the next edge.

## Test plan
- Reset then R-type 0x002081B3 with mem_ready=1: states 0,1,2,4,0. rf_we=1 and wb_sel=00 in cycle 4. instret=1.
- LOAD 0x0040A183 with mem_ready delayed 2 cycles in both FETCH and MEM: 9 cycles. mem_addr_sel=1 and mem_we=0 in MEM. wb_sel=01 at WB.
- BRANCH 0x00208463: with branch_taken=1, pc_src=01 in EXEC; with branch_taken=0, pc_src=00. Both take 3 cycles and pulse retire once.
- JALR 0x000080E7: WB asserts rf_we=1, wb_sel=10, pc_src=10. JAL 0x008000EF gives pc_src=01.
- Opcode 0x0000007F: DECODE then TRAP. illegal stays 1, mem_req stays 0 for 20 cycles. rst_n pulse clears illegal and returns to FETCH.
- rst_n low asynchronously in MEM of a STORE: mem_req and mem_we drop 0 before the next edge. instret is unchanged from 0.
